// File: rtl/lfsr_pkg.sv
// ============================================================
// lfsr_pkg : shared LFSR types, default tap masks, all-ones test
// Rev 1.0
// ============================================================
`default_nettype none

package lfsr_pkg;

  localparam int unsigned LFSR_MAX_WIDTH = 64;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    LOCK = 1'b1
  } lfsr_state_e;

  // Maximal-length XNOR tap masks; bit i set selects register bit i.
  function automatic logic [LFSR_MAX_WIDTH-1:0] default_taps(input int unsigned width);
    case (width)
      3:       return 64'h0000_0000_0000_0006;
      4:       return 64'h0000_0000_0000_000C;
      5:       return 64'h0000_0000_0000_0014;
      6:       return 64'h0000_0000_0000_0030;
      7:       return 64'h0000_0000_0000_0060;
      8:       return 64'h0000_0000_0000_00B8;
      9:       return 64'h0000_0000_0000_0110;
      10:      return 64'h0000_0000_0000_0240;
      11:      return 64'h0000_0000_0000_0500;
      12:      return 64'h0000_0000_0000_0829;
      13:      return 64'h0000_0000_0000_100D;
      14:      return 64'h0000_0000_0000_2015;
      15:      return 64'h0000_0000_0000_6000;
      16:      return 64'h0000_0000_0000_D008;
      17:      return 64'h0000_0000_0001_2000;
      18:      return 64'h0000_0000_0002_0400;
      19:      return 64'h0000_0000_0004_0023;
      20:      return 64'h0000_0000_0009_0000;
      21:      return 64'h0000_0000_0014_0000;
      22:      return 64'h0000_0000_0030_0000;
      23:      return 64'h0000_0000_0042_0000;
      24:      return 64'h0000_0000_00E1_0000;
      25:      return 64'h0000_0000_0120_0000;
      26:      return 64'h0000_0000_0200_0023;
      27:      return 64'h0000_0000_0400_0013;
      28:      return 64'h0000_0000_0900_0000;
      29:      return 64'h0000_0000_1400_0000;
      30:      return 64'h0000_0000_2000_0029;
      31:      return 64'h0000_0000_4800_0000;
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return 64'h0000_0000_0000_0000;
    endcase
  endfunction

  // True when the low 'width' bits of value are all ones.
  function automatic logic is_all_ones(input logic [LFSR_MAX_WIDTH-1:0] value,
                                       input int unsigned width);
    logic [LFSR_MAX_WIDTH-1:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return ((value | ~mask) == {LFSR_MAX_WIDTH{1'b1}});
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_gen_if.sv
// ============================================================
// lfsr_gen_if : valid/ready output stream of the LFSR generator
// Rev 1.0
// ============================================================
`default_nettype none

interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

`default_nettype wire

// File: rtl/lfsr_step.sv
// ============================================================
// lfsr_step : STEP-fold Fibonacci XNOR feedback, purely combinational
// Rev 1.0
// ============================================================
`default_nettype none

module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter int unsigned      STEP  = 1
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] w_fold;

  always_comb begin
    w_fold = cur;
    for (int unsigned i = 0; i < STEP; i++) begin
      w_fold = {w_fold[WIDTH-2:0], ~^(w_fold & TAPS)};
    end
  end

  assign nxt = w_fold;

endmodule

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ============================================================
// lfsr_gen : parametrised XNOR LFSR source with wrap/lockup detect.
// Optional LFSR_PERIOD_EN: advance counter and PERIOD capture.
// Rev 1.0
// ============================================================
`default_nettype none

module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(default_taps(WIDTH)),
  parameter int unsigned      STEP       = 1,
  parameter logic [WIDTH-1:0] RESET_SEED = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              seed_valid,
  input  logic [WIDTH-1:0]  seed_data,
  lfsr_gen_if.master        out_if,
  output logic              wrap,
  output logic              lockup,
  output logic [WIDTH-1:0]  period
);

  lfsr_state_e      r_state;
  lfsr_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] w_lfsr_adv;
  logic             r_valid;
  logic             r_wrap;
  logic             w_seed_ones;
  logic             w_advance;
  logic             w_hit;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEP  (STEP)
  ) u_step (
    .cur (r_lfsr),
    .nxt (w_lfsr_adv)
  );

  assign w_seed_ones = is_all_ones(64'(seed_data), WIDTH);
  assign w_advance   = (r_state == RUN) && en && !seed_valid && (!r_valid || out_if.ready);
  assign w_hit       = (w_lfsr_adv == r_seed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Only a seed load moves the FSM; LOCK is left solely by a usable seed.
  always_comb begin
    w_state_nxt = r_state;
    if (seed_valid) begin
      w_state_nxt = w_seed_ones ? LOCK : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= RESET_SEED;
      r_seed  <= RESET_SEED;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (seed_valid) begin
      r_lfsr  <= seed_data;
      r_seed  <= seed_data;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= w_advance && w_hit;
      if (w_advance) begin
        r_lfsr  <= w_lfsr_adv;
        r_valid <= 1'b1;
      end else if (r_valid && out_if.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_seen_wrap;

  // Counter holds advances already taken, so the wrapping advance adds one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_period    <= '0;
      r_seen_wrap <= 1'b0;
    end else if (seed_valid) begin
      r_count     <= '0;
      r_period    <= '0;
      r_seen_wrap <= 1'b0;
    end else if (w_advance) begin
      if (r_count != {WIDTH{1'b1}}) begin
        r_count <= r_count + WIDTH'(1);
      end
      if (w_hit && !r_seen_wrap) begin
        r_seen_wrap <= 1'b1;
        r_period    <= (r_count == {WIDTH{1'b1}}) ? r_count : r_count + WIDTH'(1);
      end
    end
  end

  assign period = r_period;
`else
  assign period = '0;
`endif

  assign out_if.data  = r_lfsr;
  assign out_if.valid = r_valid;
  assign wrap         = r_wrap;
  assign lockup       = (r_state == LOCK);

endmodule

`default_nettype wire

// File: tb/tb_lfsr_gen.sv
// ============================================================
// tb_lfsr_gen : directed scoreboard bench, STEP=1 and STEP=2 instances
// Rev 1.0
// ============================================================
`default_nettype none

module tb_lfsr_gen;

  typedef struct packed {
    logic [3:0] data;
    logic       wrap;
  } exp_t;

`ifdef LFSR_PERIOD_EN
  localparam logic [3:0] EXP_PERIOD = 4'd15;
`else
  localparam logic [3:0] EXP_PERIOD = 4'd0;
`endif

  localparam logic [3:0] SEQ1 [15] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                                       4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
  localparam logic [3:0] SEQ2 [15] = '{4'h3, 4'hE, 4'hB, 4'hC, 4'h2, 4'hA, 4'h8, 4'h1,
                                       4'h7, 4'hD, 4'h6, 4'h9, 4'h5, 4'h4, 4'h0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;
  logic       seed_valid = 1'b0;
  logic [3:0] seed_data = 4'h0;
  logic       seed_valid_b = 1'b0;
  logic [3:0] seed_data_b = 4'h0;
  logic       wrap_a, lockup_a, wrap_b, lockup_b;
  logic [3:0] period_a, period_b;

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t mon_a, mon_b;

  lfsr_gen_if #(.WIDTH(4)) bus_a ();
  lfsr_gen_if #(.WIDTH(4)) bus_b ();

  assign bus_b.ready = 1'b1;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .STEP(1), .RESET_SEED(4'h0)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_a),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .out_if     (bus_a),
    .wrap       (wrap_a),
    .lockup     (lockup_a),
    .period     (period_a)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .STEP(2), .RESET_SEED(4'h0)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_b),
    .seed_valid (seed_valid_b),
    .seed_data  (seed_data_b),
    .out_if     (bus_b),
    .wrap       (wrap_b),
    .lockup     (lockup_b),
    .period     (period_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [3:0] d, input logic w);
    exp_t e;
    e.data = d;
    e.wrap = w;
    return e;
  endfunction

  // Scoreboards: every accepted word is popped and compared.
  always @(negedge clk) begin
    if (rst_n && bus_a.valid && bus_a.ready) begin
      check("a_pending", 64'(q_a.size() > 0), 64'd1);
      if (q_a.size() > 0) begin
        mon_a = q_a.pop_front();
        check("a_data", 64'(bus_a.data), 64'(mon_a.data));
        check("a_wrap", 64'(wrap_a), 64'(mon_a.wrap));
      end
    end
    if (rst_n && bus_b.valid && bus_b.ready) begin
      check("b_pending", 64'(q_b.size() > 0), 64'd1);
      if (q_b.size() > 0) begin
        mon_b = q_b.pop_front();
        check("b_data", 64'(bus_b.data), 64'(mon_b.data));
        check("b_wrap", 64'(wrap_b), 64'(mon_b.wrap));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.ready = 1'b0;
    #3;
    check("rst_data_a",   64'(bus_a.data),  64'd0);
    check("rst_valid_a",  64'(bus_a.valid), 64'd0);
    check("rst_wrap_a",   64'(wrap_a),      64'd0);
    check("rst_lockup_a", 64'(lockup_a),    64'd0);
    check("rst_period_a", 64'(period_a),    64'd0);
    check("rst_data_b",   64'(bus_b.data),  64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("idle_valid_a", 64'(bus_a.valid), 64'd0);

    // Full period, STEP=1 and STEP=2 side by side.
    tick();
    for (int i = 0; i < 15; i++) begin
      q_a.push_back(mk(SEQ1[i], i == 14));
      q_b.push_back(mk(SEQ2[i], i == 14));
    end
    en_a = 1'b1;
    en_b = 1'b1;
    bus_a.ready = 1'b1;
    repeat (14) tick();
    @(negedge clk);
    check("prewrap_period_a", 64'(period_a), 64'd0);
    check("prewrap_period_b", 64'(period_b), 64'd0);
    tick();
    en_a = 1'b0;
    en_b = 1'b0;
    @(negedge clk);
    check("period_a", 64'(period_a), 64'(EXP_PERIOD));
    check("period_b", 64'(period_b), 64'(EXP_PERIOD));
    tick();
    @(negedge clk);
    check("drain_valid_a", 64'(bus_a.valid), 64'd0);
    check("drain_valid_b", 64'(bus_b.valid), 64'd0);
    check("wrap_pulse_a",  64'(wrap_a),      64'd0);

    // Consumer stall while 7 is presented.
    tick();
    q_a.push_back(mk(4'h1, 1'b0));
    q_a.push_back(mk(4'h3, 1'b0));
    q_a.push_back(mk(4'h7, 1'b0));
    q_a.push_back(mk(4'hE, 1'b0));
    en_a = 1'b1;
    repeat (3) tick();
    bus_a.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data",  64'(bus_a.data),  64'h7);
      check("stall_valid", 64'(bus_a.valid), 64'd1);
      tick();
    end
    bus_a.ready = 1'b1;
    tick();
    en_a = 1'b0;
    @(negedge clk);
    check("resume_data", 64'(bus_a.data), 64'hE);
    tick();
    @(negedge clk);
    check("resume_drain_valid", 64'(bus_a.valid), 64'd0);

    // All-ones seed locks the generator.
    tick();
    seed_data  = 4'hF;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    en_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("lock_valid",  64'(bus_a.valid), 64'd0);
      check("lock_lockup", 64'(lockup_a),    64'd1);
      tick();
    end
    check("lock_data", 64'(bus_a.data), 64'hF);
    seed_data  = 4'h6;
    seed_valid = 1'b1;
    q_a.push_back(mk(4'hC, 1'b0));
    q_a.push_back(mk(4'h9, 1'b0));
    q_a.push_back(mk(4'h2, 1'b0));
    tick();
    seed_valid = 1'b0;
    @(negedge clk);
    check("unlock_lockup", 64'(lockup_a),    64'd0);
    check("unlock_valid",  64'(bus_a.valid), 64'd0);
    check("unlock_data",   64'(bus_a.data),  64'h6);
    repeat (3) tick();
    en_a = 1'b0;
    @(negedge clk);
    tick();

    // Seed load wins over a concurrent enable.
    seed_data  = 4'h5;
    seed_valid = 1'b1;
    en_a = 1'b1;
    tick();
    seed_valid = 1'b0;
    en_a = 1'b0;
    @(negedge clk);
    check("seed_en_data",  64'(bus_a.data),  64'h5);
    check("seed_en_valid", 64'(bus_a.valid), 64'd0);
    q_a.push_back(mk(4'hA, 1'b0));
    tick();
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    @(negedge clk);
    tick();

    // Asynchronous reset while B is pending.
    seed_data  = 4'hD;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    en_a = 1'b1;
    bus_a.ready = 1'b0;
    tick();
    en_a = 1'b0;
    @(negedge clk);
    check("pre_rst_data",  64'(bus_a.data),  64'hB);
    check("pre_rst_valid", 64'(bus_a.valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data",   64'(bus_a.data),  64'd0);
    check("async_rst_valid",  64'(bus_a.valid), 64'd0);
    check("async_rst_period", 64'(period_a),    64'd0);
    check("async_rst_wrap",   64'(wrap_a),      64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus_a.ready = 1'b1;
    q_a.push_back(mk(4'h1, 1'b0));
    q_a.push_back(mk(4'h3, 1'b0));
    en_a = 1'b1;
    repeat (2) tick();
    en_a = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("restart_drain_valid", 64'(bus_a.valid), 64'd0);

    check("queue_a_empty", 64'(q_a.size()), 64'd0);
    check("queue_b_empty", 64'(q_b.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
